// File: rtl/key_stream_gen_pkg.sv
// Shared constants and helpers for the PRESENT round-key stream generator.
package key_stream_gen_pkg;

  localparam int ROT_AMT = 61;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_e;

  function automatic bit key_width_ok(input int w);
    return (w == 80) || (w == 128);
  endfunction

  // LSB of the 5-bit round-counter field XORed into the key during an update.
  function automatic int ctr_lsb(input int w);
    return (w == 128) ? 62 : 15;
  endfunction

endpackage

// File: rtl/key_stream_gen_key_step.sv
// One PRESENT key-schedule update: rotate left 61, sbox the top nibble(s),
// XOR the round counter into the width-specific counter field.
module key_step
  import key_stream_gen_pkg::*;
#(
  parameter int KEY_WIDTH = 80
) (
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic [4:0]           ctr_i,
  output logic [KEY_WIDTH-1:0] key_o
);

  localparam int NSBOX   = (KEY_WIDTH == 128) ? 2 : 1;
  localparam int CTR_LSB = ctr_lsb(KEY_WIDTH);

  logic [KEY_WIDTH-1:0] rot;
  logic [4*NSBOX-1:0]   sb_out;
  logic [KEY_WIDTH-1:0] ctr_mask;

  assign rot = {key_i[KEY_WIDTH-ROT_AMT-1:0], key_i[KEY_WIDTH-1:KEY_WIDTH-ROT_AMT]};

  for (genvar gi = 0; gi < NSBOX; gi++) begin : g_sbox
    present_sbox u_sbox (
      .nib_i(rot[KEY_WIDTH-1-4*gi -: 4]),
      .nib_o(sb_out[4*NSBOX-1-4*gi -: 4])
    );
  end

  assign ctr_mask = {{(KEY_WIDTH-5){1'b0}}, ctr_i} << CTR_LSB;
  assign key_o    = {sb_out, rot[KEY_WIDTH-4*NSBOX-1:0]} ^ ctr_mask;

endmodule

// File: rtl/present_sbox.sv
// PRESENT 4-bit substitution box.
module present_sbox (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  always_comb begin
    nib_o = 4'h0;
    case (nib_i)
      4'h0: nib_o = 4'hC;
      4'h1: nib_o = 4'h5;
      4'h2: nib_o = 4'h6;
      4'h3: nib_o = 4'hB;
      4'h4: nib_o = 4'h9;
      4'h5: nib_o = 4'h0;
      4'h6: nib_o = 4'hA;
      4'h7: nib_o = 4'hD;
      4'h8: nib_o = 4'h3;
      4'h9: nib_o = 4'hE;
      4'hA: nib_o = 4'hF;
      4'hB: nib_o = 4'h8;
      4'hC: nib_o = 4'h4;
      4'hD: nib_o = 4'h7;
      4'hE: nib_o = 4'h1;
      4'hF: nib_o = 4'h2;
      default: nib_o = 4'h0;
    endcase
  end

endmodule

// File: rtl/key_stream_gen.sv
// Sequential PRESENT round-key generator: loads a master key, then streams
// K1..K(ROUNDS+1) one per accepted cycle.
module key_stream_gen
  import key_stream_gen_pkg::*;
#(
  parameter int KEY_WIDTH = 80,
  parameter int ROUNDS    = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic                 abort,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [63:0]          rk,
  output logic [4:0]           rk_index,
  output logic                 rk_last
);

  if (!key_width_ok(KEY_WIDTH)) begin : g_bad_width
    $error("key_stream_gen: KEY_WIDTH must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("key_stream_gen: ROUNDS must be in 1..31");
  end

  localparam logic [4:0] LAST_IDX = 5'(ROUNDS);

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [4:0]           idx_q, idx_d;
  logic [4:0]           idx_inc;
  logic [KEY_WIDTH-1:0] key_stepped;

  assign idx_inc = idx_q + 5'd1;

  key_step #(.KEY_WIDTH(KEY_WIDTH)) u_step (
    .key_i(key_q),
    .ctr_i(idx_inc),
    .key_o(key_stepped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          state_d = ST_EMIT;
          key_d   = key;
          idx_d   = '0;
        end
      end
      ST_EMIT: begin
        // abort wins over a same-cycle handshake on the round-key side
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            key_d = key_stepped;
            idx_d = idx_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign key_ready = (state_q == ST_IDLE);
  assign rk_valid  = (state_q == ST_EMIT);
  assign rk        = key_q[KEY_WIDTH-1 -: 64];
  assign rk_index  = idx_q;
  assign rk_last   = rk_valid && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_key_stream_gen.sv
// Scoreboard bench for key_stream_gen: 80-bit/31, 128-bit/31 and 80-bit/1 instances.
module tb_key_stream_gen;

  typedef struct packed {
    logic [63:0] rk;
    logic [4:0]  idx;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;

  logic        a_key_valid, a_key_ready, a_abort, a_rk_valid, a_rk_ready, a_rk_last;
  logic [79:0] a_key;
  logic [63:0] a_rk;
  logic [4:0]  a_rk_index;

  logic         b_key_valid, b_key_ready, b_abort, b_rk_valid, b_rk_ready, b_rk_last;
  logic [127:0] b_key;
  logic [63:0]  b_rk;
  logic [4:0]   b_rk_index;

  logic        c_key_valid, c_key_ready, c_abort, c_rk_valid, c_rk_ready, c_rk_last;
  logic [79:0] c_key;
  logic [63:0] c_rk;
  logic [4:0]  c_rk_index;

  exp_t a_q[$];
  exp_t b_q[$];
  exp_t c_q[$];

  int errors = 0;
  int checks = 0;

  key_stream_gen #(.KEY_WIDTH(80), .ROUNDS(31)) dut_a (
    .clk(clk), .rst(rst), .key_valid(a_key_valid), .key_ready(a_key_ready), .key(a_key),
    .abort(a_abort), .rk_valid(a_rk_valid), .rk_ready(a_rk_ready), .rk(a_rk),
    .rk_index(a_rk_index), .rk_last(a_rk_last)
  );

  key_stream_gen #(.KEY_WIDTH(128), .ROUNDS(31)) dut_b (
    .clk(clk), .rst(rst), .key_valid(b_key_valid), .key_ready(b_key_ready), .key(b_key),
    .abort(b_abort), .rk_valid(b_rk_valid), .rk_ready(b_rk_ready), .rk(b_rk),
    .rk_index(b_rk_index), .rk_last(b_rk_last)
  );

  key_stream_gen #(.KEY_WIDTH(80), .ROUNDS(1)) dut_c (
    .clk(clk), .rst(rst), .key_valid(c_key_valid), .key_ready(c_key_ready), .key(c_key),
    .abort(c_abort), .rk_valid(c_rk_valid), .rk_ready(c_rk_ready), .rk(c_rk),
    .rk_index(c_rk_index), .rk_last(c_rk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference key update written straight from the algorithm description.
  function automatic logic [127:0] model_step(input logic [127:0] k, input int w, input int c);
    logic [127:0] r;
    logic [63:0]  tbl;
    logic [4:0]   cc;
    int           n;
    tbl = 64'h21748FE3DA09B65C;
    r   = '0;
    cc  = c[4:0];
    for (int i = 0; i < w; i++) r[(i + 61) % w] = k[i];
    n = int'(r[w-1 -: 4]);
    r[w-1 -: 4] = tbl[4*n +: 4];
    if (w == 128) begin
      n = int'(r[w-5 -: 4]);
      r[w-5 -: 4] = tbl[4*n +: 4];
      r[66:62] = r[66:62] ^ cc;
    end else begin
      r[19:15] = r[19:15] ^ cc;
    end
    return r;
  endfunction

  function automatic logic [63:0] top64(input logic [127:0] k, input int w);
    logic [127:0] s;
    s = k >> (w - 64);
    return s[63:0];
  endfunction

  task automatic push_exp(input int which, input logic [63:0] rkv, input int idx, input bit last);
    exp_t e;
    e.rk = rkv; e.idx = idx[4:0]; e.last = last;
    case (which)
      0: a_q.push_back(e);
      1: b_q.push_back(e);
      default: c_q.push_back(e);
    endcase
  endtask

  task automatic push_stream(input int which, input logic [127:0] key, input int w,
                             input int rounds, input int first, input int stop);
    logic [127:0] k;
    k = key;
    for (int i = 0; i <= stop; i++) begin
      if (i >= first) push_exp(which, top64(k, w), i, i == rounds);
      k = model_step(k, w, i + 1);
    end
  endtask

  task automatic load(input int which, input logic [127:0] k);
    @(posedge clk); #1;
    case (which)
      0: begin a_key = k[79:0]; a_key_valid = 1'b1; end
      1: begin b_key = k;       b_key_valid = 1'b1; end
      default: begin c_key = k[79:0]; c_key_valid = 1'b1; end
    endcase
    @(posedge clk); #1;
    a_key_valid = 1'b0; b_key_valid = 1'b0; c_key_valid = 1'b0;
  endtask

  function automatic bit ready_of(input int which);
    case (which)
      0: return a_key_ready;
      1: return b_key_ready;
      default: return c_key_ready;
    endcase
  endfunction

  task automatic wait_idle(input int which, input int budget);
    int n = 0;
    while (!ready_of(which) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!ready_of(which)) begin
      errors++;
      $display("FAIL idle_timeout dut=%0d: key_ready=0 after %0d cycles, required 1", which, budget);
    end
  endtask

  // Scoreboard monitors: every accepted round key is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_rk_valid && a_rk_ready && !a_abort) begin
      checks++;
      if (a_q.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected: rk=%h idx=%0d last=%0d, required no key", a_rk, a_rk_index, a_rk_last);
      end else begin
        e = a_q.pop_front();
        if ({a_rk, a_rk_index, a_rk_last} !== {e.rk, e.idx, e.last}) begin
          errors++;
          $display("FAIL a_key: rk=%h idx=%0d last=%0d, required rk=%h idx=%0d last=%0d",
                   a_rk, a_rk_index, a_rk_last, e.rk, e.idx, e.last);
        end else $display("a key idx=%0d rk=%h last=%0d ok", a_rk_index, a_rk, a_rk_last);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b_rk_valid && b_rk_ready && !b_abort) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: rk=%h idx=%0d last=%0d, required no key", b_rk, b_rk_index, b_rk_last);
      end else begin
        e = b_q.pop_front();
        if ({b_rk, b_rk_index, b_rk_last} !== {e.rk, e.idx, e.last}) begin
          errors++;
          $display("FAIL b_key: rk=%h idx=%0d last=%0d, required rk=%h idx=%0d last=%0d",
                   b_rk, b_rk_index, b_rk_last, e.rk, e.idx, e.last);
        end else $display("b key idx=%0d rk=%h last=%0d ok", b_rk_index, b_rk, b_rk_last);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && c_rk_valid && c_rk_ready && !c_abort) begin
      checks++;
      if (c_q.size() == 0) begin
        errors++;
        $display("FAIL c_unexpected: rk=%h idx=%0d last=%0d, required no key", c_rk, c_rk_index, c_rk_last);
      end else begin
        e = c_q.pop_front();
        if ({c_rk, c_rk_index, c_rk_last} !== {e.rk, e.idx, e.last}) begin
          errors++;
          $display("FAIL c_key: rk=%h idx=%0d last=%0d, required rk=%h idx=%0d last=%0d",
                   c_rk, c_rk_index, c_rk_last, e.rk, e.idx, e.last);
        end else $display("c key idx=%0d rk=%h last=%0d ok", c_rk_index, c_rk, c_rk_last);
      end
    end
  end

  task automatic test_reset();
    #12;
    checks++;
    if ({a_rk_valid, a_rk, a_rk_index, a_rk_last} !== 71'd0) begin
      errors++;
      $display("FAIL reset_outputs_a: valid=%0d rk=%h idx=%0d last=%0d, required all 0",
               a_rk_valid, a_rk, a_rk_index, a_rk_last);
    end
    checks++;
    if ({b_rk_valid, b_rk, b_rk_index, b_rk_last} !== 71'd0) begin
      errors++;
      $display("FAIL reset_outputs_b: valid=%0d rk=%h idx=%0d last=%0d, required all 0",
               b_rk_valid, b_rk, b_rk_index, b_rk_last);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({a_key_ready, b_key_ready, c_key_ready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_key_ready: got %b, required 111", {a_key_ready, b_key_ready, c_key_ready});
    end
    $display("test_reset done");
  endtask

  task automatic test_stream80_zero();
    int n = 0;
    a_rk_ready = 1'b1;
    push_exp(0, 64'h0000000000000000, 0, 0);
    push_exp(0, 64'hc000000000000000, 1, 0);
    push_exp(0, 64'h5000180000000001, 2, 0);
    push_stream(0, 128'd0, 80, 31, 3, 31);
    load(0, 128'd0);
    checks++;
    if ({a_rk_valid, a_key_ready, a_rk_index} !== {1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL latency80: valid=%0d key_ready=%0d idx=%0d, required 1 0 0",
               a_rk_valid, a_key_ready, a_rk_index);
    end
    while (!(a_rk_valid && a_rk_last) && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if ({a_key_ready, a_rk_valid} !== 2'b10) begin
      errors++;
      $display("FAIL end80: key_ready=%0d valid=%0d, required 1 0", a_key_ready, a_rk_valid);
    end
    checks++;
    if (a_q.size() != 0) begin
      errors++;
      $display("FAIL stream80_count: %0d keys missing, required 0", a_q.size());
    end
    $display("test_stream80_zero done");
  endtask

  task automatic test_stream128_zero();
    b_rk_ready = 1'b1;
    push_exp(1, 64'h0000000000000000, 0, 0);
    push_exp(1, 64'hcc00000000000000, 1, 0);
    push_stream(1, 128'd0, 128, 31, 2, 31);
    load(1, 128'd0);
    wait_idle(1, 100);
    checks++;
    if (b_q.size() != 0) begin
      errors++;
      $display("FAIL stream128_count: %0d keys missing, required 0", b_q.size());
    end
    $display("test_stream128_zero done");
  endtask

  task automatic test_backpressure();
    logic [3:0]  pat;
    logic        prev_stall;
    logic [63:0] prev_rk;
    logic [4:0]  prev_idx;
    int          cyc = 0;
    pat = 4'b1001;
    prev_stall = 1'b0;
    prev_rk = '0;
    prev_idx = '0;
    a_rk_ready = 1'b1;
    push_stream(0, 128'd0, 80, 31, 0, 31);
    load(0, 128'd0);
    while (!a_key_ready && cyc < 200) begin
      a_rk_ready = pat[3 - (cyc % 4)];
      @(negedge clk);
      if (prev_stall && a_rk_valid) begin
        checks++;
        if ({a_rk, a_rk_index} !== {prev_rk, prev_idx}) begin
          errors++;
          $display("FAIL stall_stable: rk=%h idx=%0d, required rk=%h idx=%0d",
                   a_rk, a_rk_index, prev_rk, prev_idx);
        end
      end
      prev_stall = a_rk_valid && !a_rk_ready;
      prev_rk = a_rk;
      prev_idx = a_rk_index;
      @(posedge clk); #1;
      cyc++;
    end
    a_rk_ready = 1'b1;
    checks++;
    if (a_q.size() != 0 || !a_key_ready) begin
      errors++;
      $display("FAIL backpressure_count: missing=%0d key_ready=%0d, required 0 1", a_q.size(), a_key_ready);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_abort();
    int n = 0;
    a_rk_ready = 1'b1;
    push_stream(0, 128'd0, 80, 31, 0, 4);
    load(0, 128'd0);
    while (a_rk_index != 5'd5 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    checks++;
    if ({a_rk_valid, a_key_ready, a_rk_index} !== {1'b0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL abort: valid=%0d key_ready=%0d idx=%0d, required 0 1 0",
               a_rk_valid, a_key_ready, a_rk_index);
    end
    checks++;
    if (a_q.size() != 0) begin
      errors++;
      $display("FAIL abort_prefix: %0d keys missing, required 0", a_q.size());
    end
    push_stream(0, 128'd0, 80, 31, 0, 31);
    load(0, 128'd0);
    wait_idle(0, 100);
    checks++;
    if (a_q.size() != 0) begin
      errors++;
      $display("FAIL abort_restart: %0d keys missing, required 0", a_q.size());
    end
    $display("test_abort done");
  endtask

  task automatic test_back_to_back();
    logic [95:0]  r1, r2;
    logic [127:0] k1, k2;
    int           n = 0;
    r1 = {$urandom, $urandom, $urandom};
    r2 = {$urandom, $urandom, $urandom};
    k1 = {48'd0, r1[79:0]};
    k2 = {48'd0, r2[79:0]};
    a_rk_ready = 1'b1;
    push_stream(0, k1, 80, 31, 0, 31);
    push_stream(0, k2, 80, 31, 0, 31);
    load(0, k1);
    while (!a_key_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    a_key = k2[79:0];
    a_key_valid = 1'b1;
    @(posedge clk); #1;
    a_key_valid = 1'b0;
    checks++;
    if ({a_rk_valid, a_rk_index} !== {1'b1, 5'd0}) begin
      errors++;
      $display("FAIL b2b_reload: valid=%0d idx=%0d, required 1 0", a_rk_valid, a_rk_index);
    end
    wait_idle(0, 100);
    checks++;
    if (a_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: %0d keys missing, required 0", a_q.size());
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_ignore_and_reset();
    logic [95:0]  r1, r2;
    logic [127:0] ka;
    int           n = 0;
    r1 = {$urandom, $urandom, $urandom};
    r2 = {$urandom, $urandom, $urandom};
    ka = {48'd0, r1[79:0]};
    a_rk_ready = 1'b1;
    push_stream(0, ka, 80, 31, 0, 31);
    load(0, ka);
    @(posedge clk); #1;
    a_key = r2[79:0] ^ 80'h1;
    a_key_valid = 1'b1;
    @(posedge clk); #1;
    a_key_valid = 1'b0;
    while (a_rk_index != 5'd10 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_rk_valid, a_rk, a_rk_index, a_rk_last} !== 71'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%0d rk=%h idx=%0d last=%0d, required all 0",
               a_rk_valid, a_rk, a_rk_index, a_rk_last);
    end
    checks++;
    if (a_q.size() != 22) begin
      errors++;
      $display("FAIL ignore_prefix: %0d keys left, required 22", a_q.size());
    end
    a_q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({a_key_ready, a_rk_valid} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset: key_ready=%0d valid=%0d, required 1 0", a_key_ready, a_rk_valid);
    end
    $display("test_ignore_and_reset done");
  endtask

  task automatic test_rounds1();
    logic [95:0]  r1;
    logic [127:0] kc;
    r1 = {$urandom, $urandom, $urandom};
    kc = {48'd0, r1[79:0]};
    c_rk_ready = 1'b1;
    push_stream(2, kc, 80, 1, 0, 1);
    load(2, kc);
    wait_idle(2, 20);
    @(posedge clk); #1;
    checks++;
    if (c_q.size() != 0 || c_rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL rounds1_count: missing=%0d valid=%0d, required 0 0", c_q.size(), c_rk_valid);
    end
    $display("test_rounds1 done");
  endtask

  initial begin
    rst = 1'b1;
    a_key_valid = 0; a_key = '0; a_abort = 0; a_rk_ready = 0;
    b_key_valid = 0; b_key = '0; b_abort = 0; b_rk_ready = 0;
    c_key_valid = 0; c_key = '0; c_abort = 0; c_rk_ready = 0;
    test_reset();
    test_stream80_zero();
    test_stream128_zero();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_ignore_and_reset();
    test_rounds1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_stream_gen.md
# key_stream_gen

Sequential PRESENT round-key generator, parametrised for 80- and 128-bit master keys and a configurable round count. It accepts a master key over a valid/ready handshake, then streams round keys K1..K(ROUNDS+1) one per cycle over a second valid/ready handshake, with backpressure. It sits between the key-load path and the round datapath of the block-cipher core, so the core no longer needs a combinational key-update chain.

## Interface

Parameters:
- KEY_WIDTH, 80: master key width; legal values 80 or 128 only (elaboration error otherwise).
- ROUNDS, 31: number of key updates; emits ROUNDS+1 round keys; legal range 1..31.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- key_valid  in  1  master key offered.
- key_ready  out  1  generator idle, able to accept a key.
- key  in  KEY_WIDTH  master key; sampled when key_valid && key_ready.
- abort  in  1  synchronous cancel of an in-progress stream.
- rk_valid  out  1  rk/rk_index/rk_last valid.
- rk_ready  in  1  consumer accepts the current round key.
- rk  out  64  round key = register bits [KEY_WIDTH-1 : KEY_WIDTH-64].
- rk_index  out  5  zero-based index; rk_index = n means K(n+1).
- rk_last  out  1  high with the final key (rk_index == ROUNDS).

## Operation

- State machine with two states:
  - IDLE: key_ready=1, rk_valid=0.
  - EMIT: key_ready=0, rk_valid=1.
- IDLE -> EMIT on key_valid && key_ready. Key register <= key; idx <= 0.
- In EMIT, when rk_ready=1:
  - If idx == ROUNDS: go to IDLE. The register holds its value.
  - Otherwise: register <= step(register, idx+1); idx <= idx+1.
- In EMIT, when rk_ready=0, all outputs hold stable. No skips.
- step(k, c) for KEY_WIDTH=80:
  - Rotate left by 61.
  - Apply the PRESENT sbox to bits [79:76].
  - XOR c into bits [19:15].
- step(k, c) for KEY_WIDTH=128:
  - Rotate left by 61.
  - Apply the sbox to bits [127:124] and to bits [123:120].
  - XOR c into bits [66:62].
- The counter c is 5 bits, values 1..ROUNDS. No wrap is possible within the legal range.
- abort is sampled on every edge:
  - In EMIT: go to IDLE and clear idx to 0. abort has priority over rk_ready.
  - In IDLE: no effect. A key handshake in the same cycle still loads.
- key_valid during EMIT is ignored (key_ready=0). The source must hold the key until accepted.

## Timing

- Reset (async assert, held while rst=1):
  - State IDLE; key register 0; idx 0.
  - key_ready=1 once rst deasserts.
  - rk_valid=0, rk=0, rk_index=0, rk_last=0.
- Latency: key accepted at edge T. K1 is on rk, with rk_valid=1, after edge T.
- Throughput: one round key per cycle while rk_ready=1. With rk_ready held high, a full stream takes ROUNDS+1 cycles.
- Back-to-back streams: the final key is accepted at edge E, so key_ready=1 after E. The next key can load at E+1. There is one bubble cycle between streams.
- All outputs are registered or decoded from registered state only. There is no combinational path from rk_ready or key_valid to any output.
- Reset mid-stream: immediate return to the reset values. The stream is not resumed.

## Structure

- The shared package holds:
  - The KEY_WIDTH legality check.
  - The rotation constant 61.
  - Counter field positions per width: 80 -> [19:15]; 128 -> [66:62].
- One combinational sub-module, key_step, parametrised by KEY_WIDTH, implements step(k, c) by instantiating the existing sbox once for 80-bit keys and twice for 128-bit keys.
- key_stream_gen contains only the FSM, idx counter, key register and handshake logic.

## Test plan

- KEY_WIDTH=80, key=0, rk_ready=1 -> K1=0000000000000000, K2=c000000000000000, K3=5000180000000001. The stream ends at rk_index=31 with rk_last=1. key_ready=1 on the next cycle.
- KEY_WIDTH=128, key=0 -> K1=0000000000000000, K2=cc00000000000000. 32 keys are emitted, rk_last only on the last.
- Backpressure: KEY_WIDTH=80, key=0, rk_ready toggling 1,0,0,1 -> rk/rk_index stay stable across the stalled cycles. The sequence matches the first test with no duplicates or gaps.
- abort asserted with rk_ready=1 while rk_index=5 -> next cycle rk_valid=0, key_ready=1, rk_index=0. A new key=0 then produces K1 again.
- key_valid pulsed with a different key during EMIT -> ignored, stream unchanged. rst asserted at rk_index=10 -> outputs drop to reset values asynchronously. After release, key_ready=1.
- ROUNDS=1 -> exactly two keys. K1 has rk_last=0; K2 has rk_index=1 and rk_last=1.
